// File: rtl/fp_pkg.sv
// Shared widths, constants and FSM encoding for the float packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int FP_W   = 32;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fp_pack_lzc24.sv
// Leading-zero count of a 24-bit mantissa; all-zero input yields 24.
// Latency: combinational.
// Backpressure: n/a.
module lzc24
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] din,
    output logic [4:0]        cnt
);
    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < MANT_W; i++) begin
            if (din[i]) cnt = 5'(MANT_W - 1 - i);
        end
    end
endmodule

// File: rtl/fp_pack.sv
// Normalizes a {sign, biased exp, 24-bit mantissa} tuple and packs it as IEEE-754 single.
// Latency: 2+k edges (k left shifts), or always 2 with FP_PACK_FAST_NORM_EN defined.
// Backpressure: one tuple in flight; result held in DONE until OUT_READY.
module fp_pack
    import fp_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [MANT_W-1:0] ZN,
    input  logic [EXP_W-1:0]  ZEN,
    input  logic              ZS,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [FP_W-1:0]   FP,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);
    state_t            state, state_n;
    logic [MANT_W-1:0] m, m_n;
    logic [EXP_W-1:0]  e, e_n;
    logic              s, s_n;
    logic [FP_W-1:0]   fp_q, fp_n;

`ifdef FP_PACK_FAST_NORM_EN
    logic [4:0]        lz;
    logic [EXP_W-1:0]  shamt;
    logic [EXP_W-1:0]  e_fin;
    logic [MANT_W-1:0] m_sh;

    lzc24 u_lzc (
        .din (m),
        .cnt (lz)
    );

    // Never shift the exponent below 1; leftover leading zeros become a subnormal.
    always_comb begin
        shamt = ({3'b000, lz} < (e - 8'd1)) ? {3'b000, lz} : (e - 8'd1);
        m_sh  = m << shamt;
        e_fin = e - shamt;
    end
`endif

    always_comb begin
        state_n = state;
        m_n     = m;
        e_n     = e;
        s_n     = s;
        fp_n    = fp_q;
        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    m_n     = ZN;
                    e_n     = ZEN;
                    s_n     = ZS;
                    state_n = NORM;
                end
            end
            NORM: begin
                if (m == '0) begin
                    fp_n    = {s, 31'b0};
                    state_n = DONE;
                end else if (e == EXP_MAX) begin
                    fp_n    = {s, EXP_MAX, m[MANT_W-2:0]};
                    state_n = DONE;
                end else if (e == '0) begin
                    fp_n    = {s, 8'h00, m[MANT_W-2:0]};
                    state_n = DONE;
                end else begin
`ifdef FP_PACK_FAST_NORM_EN
                    if (m_sh[MANT_W-1]) fp_n = {s, e_fin, m_sh[MANT_W-2:0]};
                    else                fp_n = {s, 8'h00, m_sh[MANT_W-2:0]};
                    m_n     = m_sh;
                    e_n     = e_fin;
                    state_n = DONE;
`else
                    if (!m[MANT_W-1] && (e > 8'd1)) begin
                        m_n = {m[MANT_W-2:0], 1'b0};
                        e_n = e - 8'd1;
                    end else if (m[MANT_W-1]) begin
                        fp_n    = {s, e, m[MANT_W-2:0]};
                        state_n = DONE;
                    end else begin
                        fp_n    = {s, 8'h00, m[MANT_W-2:0]};
                        state_n = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (OUT_READY) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            m     <= '0;
            e     <= '0;
            s     <= 1'b0;
            fp_q  <= '0;
        end else begin
            state <= state_n;
            m     <= m_n;
            e     <= e_n;
            s     <= s_n;
            fp_q  <= fp_n;
        end
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign FP        = fp_q;
endmodule

// File: tb/tb_fp_pack.sv
// Directed checks of fp_pack: specials, normalization latency, backpressure, reset abort.
module tb_fp_pack;
    logic        CLK = 1'b0;
    logic        RST;
    logic [23:0] ZN;
    logic [7:0]  ZEN;
    logic        ZS;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] FP;
    logic        OUT_VALID;
    logic        OUT_READY;

    int checks = 0;
    int passes = 0;

`ifdef FP_PACK_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    fp_pack dut (
        .CLK       (CLK),
        .RST       (RST),
        .ZN        (ZN),
        .ZEN       (ZEN),
        .ZS        (ZS),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .FP        (FP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int lat_of(input int k);
        return FAST ? 2 : 2 + k;
    endfunction

    // Send one tuple, measure edges from accept to OUT_VALID, check result, consume it.
    task automatic run(input logic [23:0] zn, input logic [7:0] zen, input logic zs,
                       input logic [31:0] exp_fp, input int exp_lat, input string tag);
        int lat;
        @(negedge CLK);
        chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        ZN = zn; ZEN = zen; ZS = zs; IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        ZN = 24'hA5A5A5; ZEN = 8'h3C; ZS = ~zs;
        lat = 1;
        while (!OUT_VALID && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_fp"}, FP, exp_fp);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk({tag, "_drain"}, {30'd0, OUT_VALID, IN_READY}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          lat;
        bit          stale;

        RST = 1'b1; ZN = '0; ZEN = '0; ZS = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_fp", FP, 32'h0);

        run(24'h800000, 8'h7F, 1'b0, 32'h3F800000, 2,          "one");
        run(24'h000001, 8'h96, 1'b1, 32'hBF800000, lat_of(23), "maxshift");
        run(24'h000000, 8'h55, 1'b1, 32'h80000000, 2,          "zero");
        run(24'h812345, 8'hFF, 1'b0, 32'h7F812345, 2,          "infnan");
        run(24'h200000, 8'h02, 1'b0, 32'h00400000, lat_of(1),  "subn");
        run(24'h123456, 8'h00, 1'b1, 32'h80123456, 2,          "exp0");
        run(24'h00F000, 8'h90, 1'b0, 32'h44700000, lat_of(8),  "mid");
        run(24'h000100, 8'h05, 1'b0, 32'h00001000, lat_of(4),  "elimit");

        // Backpressure: hold result, offer a competing tuple that must be ignored.
        @(negedge CLK);
        ZN = 24'h800000; ZEN = 8'h80; ZS = 1'b1; IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ZN = 24'h000003; ZEN = 8'h10; ZS = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd2);
        held = FP;
        chk("bp_fp", held, 32'hC0000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_hold_valid", 32'(OUT_VALID), 32'd1);
            chk("bp_hold_fp", FP, 32'hC0000000);
            chk("bp_hold_in_ready", 32'(IN_READY), 32'd0);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("bp_release_valid", 32'(OUT_VALID), 32'd0);
        chk("bp_release_in_ready", 32'(IN_READY), 32'd1);
        run(24'h400000, 8'h81, 1'b0, 32'h40000000, lat_of(1), "after_bp");

        // Reset during normalization of the maximum-shift tuple.
        @(negedge CLK);
        ZN = 24'h000001; ZEN = 8'h96; ZS = 1'b1; IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmid_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rstmid_fp", FP, 32'h0);
        chk("rstmid_in_ready", 32'(IN_READY), 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (OUT_VALID) stale = 1'b1;
        end
        chk("rstmid_no_stale", 32'(stale), 32'd0);
        run(24'h800000, 8'h7F, 1'b0, 32'h3F800000, 2, "after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fp_pack.md
FP_PACK -- requirements
Module: fp_pack

Interface
REQ-001 The block SHALL have no parameters; all widths come from the shared package.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset is synchronous and active-high.
REQ-004 ZN  input  24  mantissa including hidden bit; may be unnormalized.
REQ-005 ZEN  input  8  biased exponent.
REQ-006 ZS  input  1  sign.
REQ-007 IN_VALID  input  1  ZN/ZEN/ZS valid.
REQ-008 IN_READY  output  1  block can accept a tuple.
REQ-009 FP  output  32  packed IEEE-754 single {S, E[7:0], M[22:0]}.
REQ-010 OUT_VALID  output  1  FP valid.
REQ-011 OUT_READY  input  1  downstream accepts FP.

Function
REQ-012 The FSM SHALL have states IDLE, NORM and DONE; IN_READY=1 only in IDLE, and OUT_VALID=1 only in DONE.
REQ-013 IDLE: on IN_VALID=1, capture ZN/ZEN/ZS into working registers M, E and S, then go to NORM; otherwise stay in IDLE.
REQ-014 NORM, special cases, each registering FP and going to DONE in one cycle:
- M==0: FP={S,31'b0}.
- E==8'hFF: FP={S,8'hFF,M[22:0]} (Inf/NaN pass-through).
- E==0: FP={S,8'h00,M[22:0]}, no shift.
REQ-015 NORM, normal path:
- If M[23]==0 and E>1: shift M left by 1, decrement E by 1, stay in NORM.
- Else if M[23]==1: FP={S,E,M[22:0]}, go to DONE.
- Else (E==1, M[23]==0): FP={S,8'h00,M[22:0]} (subnormal), go to DONE.
REQ-016 There SHALL be no rounding; mantissa bits are never lost because only left shifts occur.
REQ-017 Latency SHALL be 2+k rising edges from the accept edge to OUT_VALID visible, where k = number of shifts (0..23).
REQ-018 DONE: FP and OUT_VALID SHALL hold stable while OUT_READY=0; on OUT_READY=1, go to IDLE with OUT_VALID=0 on the next cycle.
REQ-019 No new tuple SHALL be accepted until the current one has been consumed (one-deep; no overlap).
REQ-020 Input changes while the FSM is not in IDLE SHALL be ignored.

Reset
REQ-021 RST=1 at any clock edge, including mid-NORM or in DONE, SHALL force IDLE, FP=0, OUT_VALID=0, M=0, E=0, S=0.
REQ-022 IN_READY SHALL be 1 in the first cycle after RST deasserts.
REQ-023 An in-flight tuple aborted by RST SHALL be discarded and never output.

Configuration
REQ-024 Macro FP_PACK_FAST_NORM_EN defined: NORM SHALL complete in one cycle using shift amount min(lzc(M), E-1), with E>1 and M!=0 on the normal path; latency is always 2, and FP results are bit-identical to the iterative mode.
REQ-025 Macro undefined: the iterative one-bit-per-cycle shifter of REQ-015 is used, and the leading-zero counter is not instantiated.

Structure
REQ-026 Shared package fp_pkg SHALL hold MANT_W=24, EXP_W=8, EXP_MAX=8'hFF, FP_W=32, and the FSM state encoding.
REQ-027 Sub-module lzc24 (24-bit leading-zero counter, 5-bit combinational output) SHALL exist and be instantiated only under FP_PACK_FAST_NORM_EN.

Verification
REQ-028 Normalized input: ZN=24'h800000, ZEN=8'h7F, ZS=0 -> FP=32'h3F800000, OUT_VALID 2 edges after accept.
REQ-029 Maximum shift: ZN=24'h000001, ZEN=8'h96, ZS=1 -> FP=32'hBF800000; latency 25 iterative, 2 with FP_PACK_FAST_NORM_EN.
REQ-030 Zero and specials:
- ZN=0, ZS=1 -> FP=32'h80000000.
- ZN=24'h812345, ZEN=8'hFF, ZS=0 -> FP=32'h7F812345.
REQ-031 Subnormal: ZN=24'h200000, ZEN=8'h02, ZS=0 -> one shift, FP=32'h00400000.
REQ-032 Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID -> FP and OUT_VALID stable, IN_READY=0, and a new IN_VALID is ignored; OUT_READY=1 -> IDLE next cycle.
REQ-033 Reset mid-operation: RST=1 during NORM of the REQ-029 stimulus -> OUT_VALID=0, FP=0, and IN_READY=1 the cycle after release; no stale output appears.
